// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory responder.
// Optional byte/misalignment support is enabled by defining DMEM_BYTE_ACCESS_EN.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  localparam int DMEM_DEPTH_DEF = 64;
  localparam int DMEM_WAIT_DEF  = 2;
  // Wide enough for WAIT_CYCLES-1 over the full 0..15 wait-state range.
  localparam int DMEM_CNT_W     = 4;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between a CPU data port and dmem_responder.
// Signal set is the same with or without DMEM_BYTE_ACCESS_EN.
interface dmem_responder_if;
  import dmem_pkg::*;

  // Handshake: a transfer happens on a rising edge where valid && ready are both 1.
  // The source holds valid and its payload stable until that edge; ready may change freely.
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic        req_byte;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_byte, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_byte, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_responder_byte_lane.sv
// Little-endian byte extract/merge for one 32-bit word.
// Only compiled and used when DMEM_BYTE_ACCESS_EN is defined.
`ifdef DMEM_BYTE_ACCESS_EN
module byte_lane
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [7:0]  wbyte,
  output logic [31:0] rdata,
  output logic [31:0] merged
);

  always_comb begin
    rdata  = '0;
    merged = word;
    case (lane)
      2'd0: begin
        rdata[7:0]   = word[7:0];
        merged[7:0]  = wbyte;
      end
      2'd1: begin
        rdata[7:0]   = word[15:8];
        merged[15:8] = wbyte;
      end
      2'd2: begin
        rdata[7:0]    = word[23:16];
        merged[23:16] = wbyte;
      end
      default: begin
        rdata[7:0]    = word[31:24];
        merged[31:24] = wbyte;
      end
    endcase
  end

endmodule
`endif

// File: rtl/dmem_responder.sv
// Single-port data memory with programmable wait states and a valid/ready response.
// Define DMEM_BYTE_ACCESS_EN for byte loads/stores and word-misalignment faults.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH       = DMEM_DEPTH_DEF,
  parameter int WAIT_CYCLES = DMEM_WAIT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  dmem_responder_if.slave   bus,
  output logic [1:0]        state_dbg
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0] S_IDLE = 2'(ST_IDLE);
  localparam logic [1:0] S_WAIT = 2'(ST_WAIT);
  localparam logic [1:0] S_RESP = 2'(ST_RESP);
  localparam logic [DMEM_CNT_W-1:0] CNT_LOAD =
    (WAIT_CYCLES == 0) ? '0 : DMEM_CNT_W'(WAIT_CYCLES - 1);
  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  logic [1:0]            state;
  logic [DMEM_CNT_W-1:0] cnt;
  logic                  cap_we;
  logic                  cap_byte;
  logic [31:0]           cap_addr;
  logic [31:0]           cap_wdata;
  logic [31:0]           mem [DEPTH];

  logic        accept;
  logic        do_access;
  logic        acc_we;
  logic        acc_byte;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [31:0] word_idx;
  logic        in_range;
  logic        misalign;
  logic        acc_err;
  logic [31:0] mem_word;
  logic [31:0] load_data;
  logic [31:0] store_data;

  assign bus.req_ready = reset & (state == S_IDLE);
  assign accept        = bus.req_valid & bus.req_ready;
  assign state_dbg     = state;

  // With zero wait states the access fires on the accepting edge, so the live
  // request fields are used; otherwise the captured copy drives the access.
  assign do_access = ((state == S_IDLE) && accept && (WAIT_CYCLES == 0)) ||
                     ((state == S_WAIT) && (cnt == '0));
  assign acc_we    = (state == S_IDLE) ? bus.req_we    : cap_we;
  assign acc_byte  = (state == S_IDLE) ? bus.req_byte  : cap_byte;
  assign acc_addr  = (state == S_IDLE) ? bus.req_addr  : cap_addr;
  assign acc_wdata = (state == S_IDLE) ? bus.req_wdata : cap_wdata;

  assign word_idx = {2'b00, acc_addr[31:2]};
  assign in_range = (word_idx < DEPTH_W);
  assign mem_word = mem[word_idx[AW-1:0]];

`ifdef DMEM_BYTE_ACCESS_EN
  logic [31:0] lane_rdata;
  logic [31:0] lane_merged;

  byte_lane u_byte_lane (
    .word   (mem_word),
    .lane   (acc_addr[1:0]),
    .wbyte  (acc_wdata[7:0]),
    .rdata  (lane_rdata),
    .merged (lane_merged)
  );

  assign misalign   = !acc_byte && (acc_addr[1:0] != 2'b00);
  assign load_data  = acc_byte ? lane_rdata  : mem_word;
  assign store_data = acc_byte ? lane_merged : acc_wdata;
`else
  logic unused_lane;

  assign misalign    = 1'b0;
  assign load_data   = mem_word;
  assign store_data  = acc_wdata;
  assign unused_lane = ^{acc_byte, acc_addr[1:0]};
`endif

  assign acc_err = !in_range || misalign;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      cnt           <= '0;
      cap_we        <= 1'b0;
      cap_byte      <= 1'b0;
      cap_addr      <= '0;
      cap_wdata     <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            cap_we    <= bus.req_we;
            cap_byte  <= bus.req_byte;
            cap_addr  <= bus.req_addr;
            cap_wdata <= bus.req_wdata;
            if (WAIT_CYCLES == 0) begin
              state <= S_RESP;
            end else begin
              state <= S_WAIT;
              cnt   <= CNT_LOAD;
            end
          end
        end
        S_WAIT: begin
          if (cnt == '0) state <= S_RESP;
          else           cnt   <= cnt - 1'b1;
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            state         <= S_IDLE;
            bus.rsp_valid <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (do_access) begin
        bus.rsp_valid <= 1'b1;
        bus.rsp_rdata <= (acc_we || acc_err) ? 32'h0 : load_data;
        bus.rsp_err   <= acc_err;
      end
    end
  end

  // Memory is deliberately outside the reset domain; a reset cannot reach
  // do_access, so an aborted store never commits.
  always_ff @(posedge clk) begin
    if (do_access && acc_we && !acc_err)
      mem[word_idx[AW-1:0]] <= store_data;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (WAIT_CYCLES=2 and WAIT_CYCLES=0 instances).
// Byte-lane vectors are selected when DMEM_BYTE_ACCESS_EN is defined.
module tb_dmem_responder;

  logic clk;
  logic reset;
  logic [1:0] state_dbg;
  logic [1:0] state_dbg0;
  int checks;
  int failures;

  dmem_responder_if bus ();
  dmem_responder_if bus0 ();

  dmem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  dmem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) u_dut0 (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus0),
    .state_dbg (state_dbg0)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Returns at the falling edge of the first cycle after acceptance.
  task automatic issue_req(input string tag, input logic we, input logic bt,
                           input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    n = 0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_byte  = bt;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    while (bus.req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, {31'b0, bus.req_ready}, 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (bus.rsp_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic finish_rsp(input string tag);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check({tag, "_drop"}, {31'b0, bus.rsp_valid}, 32'd0);
  endtask

  task automatic xact(input string tag, input logic we, input logic bt,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input logic exp_err);
    int lat;
    issue_req(tag, we, bt, addr, wdata);
    wait_rsp(lat);
    check({tag, "_lat"}, 32'(lat), 32'd3);
    check({tag, "_rdata"}, bus.rsp_rdata, exp_rdata);
    check({tag, "_err"}, {31'b0, bus.rsp_err}, {31'b0, exp_err});
    finish_rsp(tag);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] z0_data [4];
  initial begin
    int lat;
    checks   = 0;
    failures = 0;
    z0_data  = '{32'hA1, 32'hB2C3, 32'hD4E5F6, 32'h0789ABCD};

    reset = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_byte = 1'b0;
    bus.req_addr  = '0;   bus.req_wdata = '0; bus.rsp_ready = 1'b0;
    bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_byte = 1'b0;
    bus0.req_addr  = '0;   bus0.req_wdata = '0; bus0.rsp_ready = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_ready", {31'b0, bus.req_ready}, 32'd0);
    check("rst_valid", {31'b0, bus.rsp_valid}, 32'd0);
    check("rst_rdata", bus.rsp_rdata, 32'd0);
    check("rst_err",   {31'b0, bus.rsp_err}, 32'd0);
    check("rst_state", {30'b0, state_dbg}, 32'd0);
    check("rst_ready0", {31'b0, bus0.req_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("post_rst_ready", {31'b0, bus.req_ready}, 32'd1);

    // Basic word store / load
    xact("st64", 1'b1, 1'b0, 32'h64, 32'h7, 32'h0, 1'b0);
    xact("ld64", 1'b0, 1'b0, 32'h64, 32'h0, 32'h7, 1'b0);

    // Byte lanes
    xact("st60", 1'b1, 1'b0, 32'h60, 32'h11223344, 32'h0, 1'b0);
`ifdef DMEM_BYTE_ACCESS_EN
    xact("stb61", 1'b1, 1'b1, 32'h61, 32'h000000AA, 32'h0, 1'b0);
    xact("ldb61", 1'b0, 1'b1, 32'h61, 32'h0, 32'h000000AA, 1'b0);
    xact("ldb63", 1'b0, 1'b1, 32'h63, 32'h0, 32'h00000011, 1'b0);
    xact("ld60",  1'b0, 1'b0, 32'h60, 32'h0, 32'h1122AA44, 1'b0);
    xact("ld62",  1'b0, 1'b0, 32'h62, 32'h0, 32'h0, 1'b1);
`else
    xact("stb61", 1'b1, 1'b1, 32'h61, 32'h000000AA, 32'h0, 1'b0);
    xact("ld62",  1'b0, 1'b0, 32'h62, 32'h0, 32'h000000AA, 1'b0);
    xact("ld60",  1'b0, 1'b0, 32'h60, 32'h0, 32'h000000AA, 1'b0);
`endif

    // Range boundary
    xact("stfc",  1'b1, 1'b0, 32'hFC,  32'hDEADBEEF, 32'h0, 1'b0);
    xact("ldfc",  1'b0, 1'b0, 32'hFC,  32'h0, 32'hDEADBEEF, 1'b0);
    xact("ld100", 1'b0, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1);
    xact("st100", 1'b1, 1'b0, 32'h100, 32'h55, 32'h0, 1'b1);

    // Response stall with ignored request pulses
    xact("st10", 1'b1, 1'b0, 32'h10, 32'h12345678, 32'h0, 1'b0);
    issue_req("stall", 1'b0, 1'b0, 32'h10, 32'h0);
    wait_rsp(lat);
    check("stall_lat", 32'(lat), 32'd3);
    for (int i = 0; i < 5; i++) begin
      bus.req_valid = (i % 2 == 0);
      bus.req_we    = 1'b1;
      bus.req_addr  = 32'h10;
      bus.req_wdata = 32'h00000BAD;
      check("stall_valid", {31'b0, bus.rsp_valid}, 32'd1);
      check("stall_rdata", bus.rsp_rdata, 32'h12345678);
      check("stall_err",   {31'b0, bus.rsp_err}, 32'd0);
      check("stall_ready", {31'b0, bus.req_ready}, 32'd0);
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    finish_rsp("stall");
    xact("ld10", 1'b0, 1'b0, 32'h10, 32'h0, 32'h12345678, 1'b0);

    // Reset during WAIT aborts a store
    xact("st40", 1'b1, 1'b0, 32'h40, 32'h9, 32'h0, 1'b0);
    issue_req("abort", 1'b1, 1'b0, 32'h40, 32'h5);
    check("abort_in_wait", {30'b0, state_dbg}, 32'd1);
    reset = 1'b0;
    #1;
    check("abort_ready", {31'b0, bus.req_ready}, 32'd0);
    check("abort_valid", {31'b0, bus.rsp_valid}, 32'd0);
    check("abort_rdata", bus.rsp_rdata, 32'd0);
    check("abort_err",   {31'b0, bus.rsp_err}, 32'd0);
    check("abort_state", {30'b0, state_dbg}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    xact("ld40", 1'b0, 1'b0, 32'h40, 32'h0, 32'h9, 1'b0);

    // Zero-wait instance: back-to-back stores then loads, rsp_ready tied high
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("z0_ready", {31'b0, bus0.req_ready}, 32'd1);
      check("z0_idle_valid", {31'b0, bus0.rsp_valid}, 32'd0);
      bus0.req_valid = 1'b1;
      bus0.req_we    = (i < 4);
      bus0.req_addr  = 32'((i % 4) * 4 + 8);
      bus0.req_wdata = z0_data[i % 4];
      @(negedge clk);
      check("z0_rsp_valid", {31'b0, bus0.rsp_valid}, 32'd1);
      check("z0_busy", {31'b0, bus0.req_ready}, 32'd0);
      check("z0_rdata", bus0.rsp_rdata, (i < 4) ? 32'h0 : z0_data[i % 4]);
      check("z0_err", {31'b0, bus0.rsp_err}, 32'd0);
    end
    bus0.req_valid = 1'b0;
    @(negedge clk);
    check("z0_final_valid", {31'b0, bus0.rsp_valid}, 32'd0);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
- REQ-001: Parameter DEPTH, default 64: memory size in 32-bit words.
- REQ-002: Parameter WAIT_CYCLES, default 2: wait states between request acceptance and access, range 0..15.
- REQ-003: clk  in  1  single clock; all state changes on the rising edge.
- REQ-004: reset  in  1  asynchronous, active-low reset.
- REQ-005: req_valid  in  1  request present.
- REQ-006: req_ready  out  1  responder accepts a request this cycle.
- REQ-007: req_we  in  1  1 = store, 0 = load.
- REQ-008: req_byte  in  1  1 = byte access (LDRB/STRB), 0 = word access.
- REQ-009: req_addr  in  32  byte address.
- REQ-010: req_wdata  in  32  store data; a byte store uses bits [7:0].
- REQ-011: rsp_valid  out  1  response present.
- REQ-012: rsp_ready  in  1  initiator accepts the response.
- REQ-013: rsp_rdata  out  32  load data; 0 for stores and errors.
- REQ-014: rsp_err  out  1  access faulted.

Function
- REQ-015: The FSM SHALL have three states: IDLE, WAIT and RESP.
- REQ-016: In IDLE, req_ready SHALL be 1; it SHALL be 0 in WAIT, in RESP and during reset.
- REQ-017: On req_valid&req_ready, the block SHALL capture we, byte, addr and wdata.
  - If WAIT_CYCLES=0, it SHALL go to RESP.
  - Otherwise it SHALL go to WAIT and load the counter with WAIT_CYCLES-1.
- REQ-018: In WAIT, the counter SHALL decrement each cycle; at 0 the access SHALL execute and the FSM SHALL go to RESP.
- REQ-019: The memory access SHALL execute on the clock edge that enters RESP, exactly once.
  - Load data SHALL be registered into rsp_rdata on that edge.
- REQ-020: Acceptance-to-rsp_valid latency SHALL be WAIT_CYCLES+1 cycles.
- REQ-021: In RESP, rsp_valid SHALL be 1, and rsp_rdata/rsp_err SHALL hold stable until rsp_ready=1.
  - On that handshake the FSM SHALL return to IDLE.
  - rsp_valid SHALL be 0 in the following cycle.
- REQ-022: req_valid in WAIT or RESP SHALL be ignored; there SHALL be no request acceptance in the response-handshake cycle.
- REQ-023: Word index SHALL be addr[31:2]. An index >= DEPTH SHALL give rsp_err=1, rsp_rdata=0 and no memory update.
- REQ-024: Every store SHALL produce a response with rsp_rdata=0.
- REQ-025: Word load SHALL return the full word; word store SHALL write all 32 bits.

Reset
- REQ-026: While reset=0, the block SHALL hold state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0 and req_ready=0.
- REQ-027: Reset asserted in WAIT SHALL abort the transaction; an uncommitted store SHALL never be written.
- REQ-028: Memory contents SHALL NOT be reset.
- REQ-029: The first request SHALL be acceptable in the first cycle after reset deasserts.

Configuration
- REQ-030: Macro DMEM_BYTE_ACCESS_EN defined: byte access SHALL be little-endian, with lane = addr[1:0].
  - Byte load SHALL return the zero-extended lane byte.
  - Byte store SHALL update only that lane with wdata[7:0].
  - A word access with addr[1:0]!=0 SHALL give rsp_err=1 and no memory update.
- REQ-031: Macro undefined: req_byte SHALL be ignored and addr[1:0] SHALL be ignored; all accesses SHALL be word accesses with no misalignment error.

Structure
- REQ-032: Shared package dmem_pkg SHALL hold:
  - the state enum typedef (IDLE/WAIT/RESP);
  - the default DEPTH and WAIT_CYCLES constants;
  - the counter width constant.
- REQ-033: One sub-module, byte_lane, SHALL perform combinational byte extract (load) and byte merge (store).
  - It SHALL be instantiated only under DMEM_BYTE_ACCESS_EN.

Verification
- REQ-034: Word store addr 0x64 data 7, then word load 0x64 -> rsp_rdata=0x00000007, rsp_err=0, rsp_valid exactly 3 cycles after each acceptance (WAIT_CYCLES=2).
- REQ-035: With macro: word store 0x60 data 0x11223344, byte store 0x61 data 0xAA, byte load 0x61 -> 0x000000AA; word load 0x60 -> 0x1122AA44.
- REQ-036: Load addr 0x100 (index 64, DEPTH=64) -> rsp_err=1, rsp_rdata=0; with macro, word load 0x62 -> rsp_err=1.
- REQ-037: Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_rdata and rsp_err stable; req_valid pulses meanwhile are not accepted (req_ready=0).
- REQ-038: Assert reset one cycle after accepting store 0x40 data 0x5 -> all outputs reset; a later load 0x40 returns the prior contents, not 5.
- REQ-039: WAIT_CYCLES=0 build: back-to-back loads with rsp_ready tied 1 -> one response every 2 cycles, correct data.
